// File: rtl/stream_record_framer.sv
// Cuts a continuous byte stream into records of the form
// [variable field][delimiter][fixed field], with valid/ready on both sides.
// Bytes that follow a record stay in the buffer and start the next record.
module stream_record_framer #(
    parameter int unsigned DATA_BUS_WIDTH_BYTES     = 8,
    parameter int unsigned MAX_VARIABLEFIELD_LENGTH = 16,
    parameter int unsigned FIXEDFIELD_LENGTH_BYTES  = 17,
    parameter logic [7:0]  RESET_DELIMITER          = 8'h2c,
    localparam int unsigned MAX_RECORD_BYTES =
        MAX_VARIABLEFIELD_LENGTH + 1 + FIXEDFIELD_LENGTH_BYTES,
    localparam int unsigned BUF_BYTES = MAX_RECORD_BYTES + DATA_BUS_WIDTH_BYTES - 1,
    localparam int unsigned LEN_W     = $clog2(MAX_RECORD_BYTES + 1),
    localparam int unsigned FILL_W    = $clog2(BUF_BYTES + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_BUS_WIDTH_BYTES*8-1:0] dataIn,
    input  logic                            dataInValid,
    output logic                            dataInReady,
    input  logic [7:0]                      delimiterIn,
    output logic [MAX_RECORD_BYTES*8-1:0]   recordOut,
    output logic [LEN_W-1:0]                recordLengthOut,
    output logic                            recordError,
    output logic                            recordValid,
    input  logic                            recordReady,
    output logic [15:0]                     recordCount,
    output logic [7:0]                      errorCount
);

    localparam int unsigned BUF_BITS     = BUF_BYTES * 8;
    localparam int unsigned REC_BITS     = MAX_RECORD_BYTES * 8;
    localparam int unsigned OVERLONG_LEN = MAX_VARIABLEFIELD_LENGTH + 1;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BUF_BITS-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [7:0]            delim_q, delim_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [REC_BITS-1:0]   rec_q, rec_d;
    logic [15:0]           rec_cnt_q, rec_cnt_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  delim_found;
    logic [LEN_W-1:0]      delim_idx;
    logic [LEN_W-1:0]      good_len;
    logic [LEN_W-1:0]      sel_len;
    logic                  complete;
    logic                  overlong;
    logic                  accept;
    logic [REC_BITS-1:0]   rec_sel;

    // Earliest delimiter among the buffered bytes of the variable-field window
    always_comb begin
        delim_found = 1'b0;
        delim_idx   = '0;
        for (int unsigned i = 0; i <= MAX_VARIABLEFIELD_LENGTH; i++) begin
            if (!delim_found && (FILL_W'(i) < fill_q) &&
                (buf_q[i*8 +: 8] == delim_q)) begin
                delim_found = 1'b1;
                delim_idx   = LEN_W'(i);
            end
        end
    end

    assign good_len = delim_idx + LEN_W'(FIXEDFIELD_LENGTH_BYTES + 1);
    assign complete = delim_found && (FILL_W'(good_len) <= fill_q);
    assign overlong = !delim_found && (fill_q >= FILL_W'(OVERLONG_LEN));
    assign sel_len  = complete ? good_len : LEN_W'(OVERLONG_LEN);

    // Record payload: leading sel_len buffer bytes, everything above zeroed
    always_comb begin
        rec_sel = '0;
        for (int unsigned i = 0; i < MAX_RECORD_BYTES; i++) begin
            if (LEN_W'(i) < sel_len) begin
                rec_sel[i*8 +: 8] = buf_q[i*8 +: 8];
            end
        end
    end

    assign dataInReady = (state_q == ST_SCAN) && !complete && !overlong;
    assign accept      = dataInValid && dataInReady;

    // Next-state: append beats while scanning, hold the record while emitting,
    // and drop the consumed bytes from the bottom of the buffer on handshake
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        delim_d   = delim_q;
        valid_d   = valid_q;
        err_d     = err_q;
        len_d     = len_q;
        rec_d     = rec_q;
        rec_cnt_d = rec_cnt_q;
        err_cnt_d = err_cnt_q;

        if ((state_q == ST_SCAN) && (fill_q == '0)) begin
            delim_d = delimiterIn;
        end

        case (state_q)
            ST_SCAN: begin
                if (complete || overlong) begin
                    state_d = ST_EMIT;
                    valid_d = 1'b1;
                    err_d   = !complete;
                    len_d   = sel_len;
                    rec_d   = rec_sel;
                end else if (accept) begin
                    // Bytes at and above fill are always zero, so OR-in is a write
                    buf_d  = buf_q | (BUF_BITS'(dataIn) << {fill_q, 3'b000});
                    fill_d = fill_q + FILL_W'(DATA_BUS_WIDTH_BYTES);
                end
            end
            ST_EMIT: begin
                if (recordReady) begin
                    state_d = ST_SCAN;
                    valid_d = 1'b0;
                    buf_d   = buf_q >> {len_q, 3'b000};
                    fill_d  = fill_q - FILL_W'(len_q);
                    if (err_q) begin
                        if (err_cnt_q != 8'hff) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        rec_cnt_d = rec_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SCAN;
            buf_q     <= '0;
            fill_q    <= '0;
            delim_q   <= RESET_DELIMITER;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            rec_q     <= '0;
            rec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            delim_q   <= delim_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            len_q     <= len_d;
            rec_q     <= rec_d;
            rec_cnt_q <= rec_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign recordOut       = rec_q;
    assign recordLengthOut = len_q;
    assign recordError     = err_q;
    assign recordValid     = valid_q;
    assign recordCount     = rec_cnt_q;
    assign errorCount      = err_cnt_q;

endmodule

// File: tb/tb_stream_record_framer.sv
// Bench for stream_record_framer: directed and random byte streams, checked
// against a record parser that works directly on the whole golden stream.
module tb_stream_record_framer;

    localparam int W      = 8;
    localparam int MAXV   = 16;
    localparam int FIX    = 17;
    localparam int MAXREC = MAXV + 1 + FIX;
    localparam int LEN_W  = $clog2(MAXREC + 1);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [W*8-1:0]      dataIn = '0;
    logic                dataInValid = 1'b0;
    logic                dataInReady;
    logic [7:0]          delimiterIn = 8'h2c;
    logic [MAXREC*8-1:0] recordOut;
    logic [LEN_W-1:0]    recordLengthOut;
    logic                recordError;
    logic                recordValid;
    logic                recordReady = 1'b0;
    logic [15:0]         recordCount;
    logic [7:0]          errorCount;

    stream_record_framer #(
        .DATA_BUS_WIDTH_BYTES    (W),
        .MAX_VARIABLEFIELD_LENGTH(MAXV),
        .FIXEDFIELD_LENGTH_BYTES (FIX),
        .RESET_DELIMITER         (8'h2c)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dataIn         (dataIn),
        .dataInValid    (dataInValid),
        .dataInReady    (dataInReady),
        .delimiterIn    (delimiterIn),
        .recordOut      (recordOut),
        .recordLengthOut(recordLengthOut),
        .recordError    (recordError),
        .recordValid    (recordValid),
        .recordReady    (recordReady),
        .recordCount    (recordCount),
        .errorCount     (errorCount)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]          stim_q[$];
    int                  beat_idx;
    int                  exp_len[$];
    bit                  exp_err[$];
    logic [MAXREC*8-1:0] exp_data[$];
    int                  cap_len[$];
    bit                  cap_err[$];
    logic [MAXREC*8-1:0] cap_data[$];
    int                  accept_iter[$];
    int                  first_valid_iter;

    function automatic void push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(8'(s[i]));
    endfunction

    function automatic void push_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(8'(start + 8'(i)));
    endfunction

    function automatic void pad_stream();
        while ((stim_q.size() % W) != 0) stim_q.push_back(8'h00);
    endfunction

    function automatic logic [7:0] non_delim(input logic [7:0] delim);
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == delim) b = b + 8'd1;
        return b;
    endfunction

    // Reference parser: walk the complete stream record by record; a record is
    // emitted only if all of its bytes exist in the stream
    function automatic void build_expected(input logic [7:0] delim);
        int p, total, d, len;
        bit err, done;
        logic [MAXREC*8-1:0] data;
        exp_len.delete(); exp_err.delete(); exp_data.delete();
        p = 0; total = stim_q.size(); done = 1'b0;
        while (!done) begin
            d = -1;
            for (int i = 0; i <= MAXV; i++)
                if (d < 0 && p + i < total && stim_q[p + i] == delim) d = i;
            if (d >= 0) begin len = d + 1 + FIX; err = 1'b0; end
            else        begin len = MAXV + 1;    err = 1'b1; end
            if (p + len > total) begin
                done = 1'b1;
            end else begin
                data = '0;
                for (int i = 0; i < len; i++) data[i*8 +: 8] = stim_q[p + i];
                exp_len.push_back(len); exp_err.push_back(err); exp_data.push_back(data);
                p += len;
            end
        end
    endfunction

    function automatic int count_err();
        int n = 0;
        foreach (exp_err[i]) if (exp_err[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b1; dataInValid = 1'b0; recordReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic clear_run();
        stim_q.delete(); beat_idx = 0;
        cap_len.delete(); cap_err.delete(); cap_data.delete();
        accept_iter.delete(); first_valid_iter = -1;
        dataInValid = 1'b0; recordReady = 1'b0;
    endtask

    task automatic drive_beat(input bit en);
        int nb = stim_q.size() / W;
        dataInValid = en && (beat_idx < nb);
        for (int i = 0; i < W; i++)
            dataIn[i*8 +: 8] = (beat_idx < nb) ? stim_q[beat_idx*W + i] : 8'h00;
    endtask

    // Feed the remaining beats and collect records until the expected number
    // has arrived, then drain a few cycles to catch spurious extras
    task automatic run_stream(input int valid_pct, input int ready_pct,
                              input int max_cycles, output bit timed_out);
        int it = 0, drain = 0, nb;
        bit stop = 1'b0;
        nb = stim_q.size() / W;
        timed_out = 1'b0;
        while (!stop) begin
            if (it >= max_cycles) begin
                timed_out = 1'b1; stop = 1'b1;
            end else begin
                if (beat_idx >= nb && cap_len.size() >= exp_len.size()) drain++;
                if (drain > 4) begin
                    stop = 1'b1;
                end else begin
                    drive_beat($urandom_range(1, 100) <= valid_pct);
                    recordReady = (drain > 0) || ($urandom_range(1, 100) <= ready_pct);
                    if (recordValid && first_valid_iter < 0) first_valid_iter = it;
                    if (dataInValid && dataInReady) begin
                        accept_iter.push_back(it); beat_idx++;
                    end
                    if (recordValid && recordReady) begin
                        cap_len.push_back(int'(recordLengthOut));
                        cap_err.push_back(recordError);
                        cap_data.push_back(recordOut);
                    end
                    @(posedge clk); #1;
                    it++;
                end
            end
        end
        dataInValid = 1'b0; recordReady = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (recordValid !== 1'b0 || recordError !== 1'b0 || recordLengthOut !== '0 ||
            recordOut !== '0 || recordCount !== 16'd0 || errorCount !== 8'd0 || dataInReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got valid %b err %b len %0d cnt %0d ecnt %0d rdy %b, need 0 0 0 0 0 1",
                     recordValid, recordError, recordLengthOut, recordCount, errorCount, dataInReady);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (recordValid !== 1'b0 || dataInReady !== 1'b1 || recordLengthOut !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got valid %b rdy %b len %0d, need 0 1 0",
                         k, recordValid, dataInReady, recordLengthOut);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        do_reset(); clear_run();
        push_str("ABC,"); push_seq(8'h41, 17); push_str("XY,"); push_seq(8'h41, 17); pad_stream();
        build_expected(8'h2c);
        run_stream(100, 100, 400, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL b2b_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                         i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (cap_len.size() < 2 || cap_len[0] != 21 || cap_len[1] != 20) begin
            n_fail++; $display("FAIL b2b_lengths: got %0d records with first lengths %p, need 21 then 20", cap_len.size(), cap_len);
        end
        n_cmp++;
        if (recordCount !== 16'd2 || errorCount !== 8'd0) begin
            n_fail++; $display("FAIL b2b_counters: got %0d/%0d, need 2/0", recordCount, errorCount);
        end
    endtask

    task automatic test_field_extremes();
        bit to;
        do_reset(); clear_run();
        push_str(","); push_seq(8'h30, 17);
        push_seq(8'h61, 16); push_str(","); push_seq(8'h41, 17); pad_stream();
        build_expected(8'h2c);
        run_stream(100, 100, 400, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ext_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL ext_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL ext_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                         i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (cap_len.size() < 2 || cap_len[0] != 18 || cap_len[1] != 34) begin
            n_fail++; $display("FAIL ext_lengths: got %p, need 18 then 34", cap_len);
        end
        // the third beat completes the 18-byte record; valid follows two cycles later
        n_cmp++;
        if (accept_iter.size() < 3 || first_valid_iter != accept_iter[2] + 2) begin
            n_fail++; $display("FAIL ext_latency: got first valid at cycle %0d, need %0d",
                               first_valid_iter, (accept_iter.size() < 3) ? -1 : accept_iter[2] + 2);
        end
    endtask

    task automatic test_overlong();
        bit to;
        do_reset(); clear_run();
        push_seq(8'h61, 17); push_str("AB,"); push_seq(8'h41, 17); pad_stream();
        build_expected(8'h2c);
        run_stream(70, 70, 600, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovl_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL ovl_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL ovl_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                         i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (cap_len.size() < 2 || cap_len[0] != 17 || cap_err[0] != 1'b1 || cap_len[1] != 20 || cap_err[1] != 1'b0) begin
            n_fail++; $display("FAIL ovl_shape: got lens %p errs %p, need 17/1 then 20/0", cap_len, cap_err);
        end
        n_cmp++;
        if (recordCount !== 16'd1 || errorCount !== 8'd1) begin
            n_fail++; $display("FAIL ovl_counters: got %0d/%0d, need 1/1", recordCount, errorCount);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int guard = 0;
        logic [MAXREC*8-1:0] snap_out;
        logic [LEN_W-1:0]    snap_len;
        do_reset(); clear_run();
        push_str("ABC,"); push_seq(8'h41, 17); push_str("XY,"); push_seq(8'h41, 17);
        push_str("LMNOP,"); push_seq(8'h61, 17); pad_stream();
        build_expected(8'h2c);
        while (!recordValid && guard < 40) begin
            drive_beat(1'b1); recordReady = 1'b0;
            if (dataInValid && dataInReady) beat_idx++;
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (recordValid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got valid %b, need 1", recordValid); end
        snap_out = recordOut; snap_len = recordLengthOut;
        for (int k = 0; k < 6; k++) begin
            drive_beat(1'b1); recordReady = 1'b0;
            n_cmp++;
            if (dataInReady !== 1'b0 || recordValid !== 1'b1 || recordOut !== snap_out || recordLengthOut !== snap_len) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got rdy %b valid %b len %0d, need 0 1 %0d with stable data",
                         k, dataInReady, recordValid, recordLengthOut, snap_len);
            end
            @(posedge clk); #1;
        end
        run_stream(100, 100, 400, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL bp_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                         i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_fixed_delim();
        bit to;
        do_reset(); clear_run();
        push_str("QRS,"); push_seq(8'h41, 17);
        stim_q[4 + 3] = 8'h2c; stim_q[4 + 10] = 8'h2c;
        push_str("TU,"); push_seq(8'h61, 17); pad_stream();
        build_expected(8'h2c);
        run_stream(70, 70, 600, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL fix_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL fix_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL fix_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                         i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (cap_len.size() < 2 || cap_len[0] != 21 || cap_len[1] != 20) begin
            n_fail++; $display("FAIL fix_lengths: got %p, need 21 then 20", cap_len);
        end
    endtask

    task automatic test_reset_midrecord();
        bit to;
        int acc = 0, guard = 0;
        do_reset(); clear_run();
        push_str("ABC,"); push_seq(8'h41, 17); pad_stream();
        build_expected(8'h2c);
        run_stream(100, 100, 400, to);
        n_cmp++;
        if (to !== 1'b0 || recordCount !== 16'd1) begin
            n_fail++; $display("FAIL rst_pre_count: got timeout %b count %0d, need 0 1", to, recordCount);
        end
        while (acc < 2 && guard < 10) begin
            dataInValid = 1'b1; dataIn = {W{8'h55}};
            if (dataInReady) acc++;
            @(posedge clk); #1;
            guard++;
        end
        dataInValid = 1'b0;
        n_cmp++; if (acc != 2) begin n_fail++; $display("FAIL rst_beats: got %0d accepted, need 2", acc); end
        do_reset();
        n_cmp++;
        if (recordValid !== 1'b0 || recordCount !== 16'd0 || errorCount !== 8'd0 || dataInReady !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got valid %b cnt %0d ecnt %0d rdy %b, need 0 0 0 1",
                               recordValid, recordCount, errorCount, dataInReady);
        end
        delimiterIn = 8'h7c;
        clear_run();
        push_str("AB|"); push_seq(8'h41, 17); pad_stream();
        build_expected(8'h7c);
        run_stream(100, 100, 400, to);
        n_cmp++;
        if (to !== 1'b0 || cap_len.size() != 1 || exp_len.size() != 1 || cap_len[0] != 20 ||
            cap_err[0] != 1'b0 || cap_data[0] !== exp_data[0]) begin
            n_fail++; $display("FAIL rst_newdelim: got %0d records lens %p timeout %b, need one 20-byte record", cap_len.size(), cap_len, to);
        end
        delimiterIn = 8'h2c;
    endtask

    task automatic test_error_saturation();
        bit to;
        do_reset(); clear_run();
        for (int i = 0; i < 260 * 17; i++) stim_q.push_back(non_delim(8'h2c));
        pad_stream();
        build_expected(8'h2c);
        run_stream(100, 100, 6000, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL sat_timeout: got timeout %b, need 0", to); end
        n_cmp++;
        if (cap_len.size() !== exp_len.size()) begin
            n_fail++; $display("FAIL sat_count: got %0d records, need %0d", cap_len.size(), exp_len.size());
        end
        for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
            n_cmp++;
            if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL sat_rec%0d: got len %0d err %b, need len %0d err %b",
                         i, cap_len[i], cap_err[i], exp_len[i], exp_err[i]);
            end
        end
        n_cmp++;
        if (errorCount !== 8'd255 || recordCount !== 16'd0) begin
            n_fail++; $display("FAIL sat_counters: got %0d/%0d, need 0/255", recordCount, errorCount);
        end
    endtask

    task automatic test_random();
        bit to;
        int n_bad, vlen;
        for (int r = 0; r < 4; r++) begin
            do_reset(); clear_run();
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    vlen = $urandom_range(17, 20);
                    for (int i = 0; i < vlen; i++) stim_q.push_back(non_delim(8'h2c));
                end else begin
                    vlen = $urandom_range(0, 16);
                    for (int i = 0; i < vlen; i++) stim_q.push_back(non_delim(8'h2c));
                    stim_q.push_back(8'h2c);
                    for (int i = 0; i < FIX; i++)
                        stim_q.push_back(($urandom_range(0, 7) == 0) ? 8'h2c : 8'($urandom_range(0, 255)));
                end
            end
            pad_stream();
            build_expected(8'h2c);
            run_stream($urandom_range(30, 100), $urandom_range(30, 100), 3000, to);
            n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: got timeout %b, need 0", r, to); end
            n_cmp++;
            if (cap_len.size() !== exp_len.size()) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d records, need %0d", r, cap_len.size(), exp_len.size());
            end
            for (int i = 0; i < exp_len.size() && i < cap_len.size(); i++) begin
                n_cmp++;
                if (cap_len[i] !== exp_len[i] || cap_err[i] !== exp_err[i] || cap_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rec%0d: got len %0d err %b data %h, need len %0d err %b data %h",
                             r, i, cap_len[i], cap_err[i], cap_data[i], exp_len[i], exp_err[i], exp_data[i]);
                end
            end
            n_bad = count_err();
            n_cmp++;
            if (recordCount !== 16'(exp_len.size() - n_bad) || errorCount !== 8'(n_bad)) begin
                n_fail++; $display("FAIL rnd%0d_counters: got %0d/%0d, need %0d/%0d",
                                   r, recordCount, errorCount, exp_len.size() - n_bad, n_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_field_extremes();
        test_overlong();
        test_backpressure();
        test_fixed_delim();
        test_reset_midrecord();
        test_error_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by 90000 cycles, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
